// File: rtl/vector_pair_streamer_if.sv
// Bundles the write port, run control and pair-stream outputs of
// vector_pair_streamer.
//   master : host/driver side (drives writes, len, start, stall)
//   slave  : streamer side (drives busy, k, l, valid, last, clear, done)
// Signals:
//   wr_en, wr_sel, wr_addr[AW-1:0], wr_data[WIDTH-1:0] : element write port
//   len[AW:0], start, stall                            : run control
//   busy, k, l, valid, last, clear, done               : stream outputs
interface vector_pair_streamer_if #(
   parameter int WIDTH = 10,
   parameter int AW    = 3
);
   logic             wr_en;
   logic             wr_sel;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW:0]      len;
   logic             start;
   logic             stall;
   logic             busy;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] l;
   logic             valid;
   logic             last;
   logic             clear;
   logic             done;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, len, start, stall,
      input  busy, k, l, valid, last, clear, done
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, len, start, stall,
      output busy, k, l, valid, last, clear, done
   );
endinterface

// File: rtl/vector_pair_streamer.sv
// Holds two operand banks (K, L) and, on start, emits an accumulator clear
// pulse followed by the pairs (k[i], l[i]) in index order, honouring stall,
// and ends with a done pulse.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset (bank contents are retained)
//   bus   : vector_pair_streamer_if.slave (write port, run control, stream)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | banks writable, waiting for start
// CLEAR  | one-cycle accumulator clear pulse
// STREAM | pair idx on k/l with valid; holds while stall=1
// DONE   | one-cycle done pulse, then back to IDLE
module vector_pair_streamer #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input logic                   clock,
   input logic                   reset,
   vector_pair_streamer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE     = (AW+1)'(1);

   state_t           state, state_n;
   logic [WIDTH-1:0] bank_k [DEPTH];
   logic [WIDTH-1:0] bank_l [DEPTH];
   logic [AW:0]      idx, idx_n, idx_inc;
   logic [AW:0]      eff_len, eff_len_n, len_clamp;
   logic [WIDTH-1:0] k_q, k_n, l_q, l_n;
   logic             valid_q, valid_n, last_q, last_n;
   logic             clear_q, clear_n, done_q, done_n, busy_q, busy_n;

   assign len_clamp = (bus.len > DEPTH_C) ? DEPTH_C : bus.len;
   assign idx_inc   = idx + ONE;

   // Banks have no reset; a write coinciding with start lands before the
   // first pair is read two edges later, so the run sees it.
   always_ff @(posedge clock) begin
      if (!reset && state == IDLE && bus.wr_en) begin
         if (bus.wr_sel) bank_l[bus.wr_addr] <= bus.wr_data;
         else            bank_k[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         eff_len <= '0;
         k_q     <= '0;
         l_q     <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         clear_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         eff_len <= eff_len_n;
         k_q     <= k_n;
         l_q     <= l_n;
         valid_q <= valid_n;
         last_q  <= last_n;
         clear_q <= clear_n;
         done_q  <= done_n;
         busy_q  <= busy_n;
      end
   end

   // Next-state logic also computes the next registered outputs, so every
   // output reflects the state being entered.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      eff_len_n = eff_len;
      k_n       = '0;
      l_n       = '0;
      valid_n   = 1'b0;
      last_n    = 1'b0;
      clear_n   = 1'b0;
      done_n    = 1'b0;
      busy_n    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               eff_len_n = len_clamp;
               idx_n     = '0;
               busy_n    = 1'b1;
               if (len_clamp == '0) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = CLEAR;
                  clear_n = 1'b1;
               end
            end
         end
         CLEAR: begin
            state_n = STREAM;
            busy_n  = 1'b1;
            valid_n = 1'b1;
            k_n     = bank_k[0];
            l_n     = bank_l[0];
            last_n  = (eff_len == ONE);
         end
         STREAM: begin
            busy_n = 1'b1;
            if (bus.stall) begin
               k_n     = k_q;
               l_n     = l_q;
               valid_n = 1'b1;
               last_n  = last_q;
            end else if (last_q) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               idx_n   = idx_inc;
               valid_n = 1'b1;
               k_n     = bank_k[idx_inc[AW-1:0]];
               l_n     = bank_l[idx_inc[AW-1:0]];
               last_n  = (idx_inc == eff_len - ONE);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy  = busy_q;
   assign bus.k     = k_q;
   assign bus.l     = l_q;
   assign bus.valid = valid_q;
   assign bus.last  = last_q;
   assign bus.clear = clear_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_vector_pair_streamer.sv
module tb_vector_pair_streamer;

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 0;

   vector_pair_streamer_if #(.WIDTH(10), .AW(3)) vif();

   vector_pair_streamer #(.WIDTH(10), .DEPTH(8), .AW(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (vif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a run is a list of events (clear, pairs, done). The
   // head event is what the outputs show; a pair event only retires when
   // stall is low. An empty list means idle.
   typedef struct {
      int         kind;   // 0 clear, 1 pair, 2 done
      logic [9:0] k;
      logic [9:0] l;
      bit         last;
   } ev_t;

   ev_t        evq[$];
   logic [9:0] mk [8];
   logic [9:0] ml [8];

   always @(posedge clock) begin
      if (reset) begin
         evq.delete();
      end else if (evq.size() == 0) begin
         if (vif.wr_en) begin
            if (vif.wr_sel) ml[vif.wr_addr] = vif.wr_data;
            else            mk[vif.wr_addr] = vif.wr_data;
         end
         if (vif.start) begin
            int   n;
            ev_t  e;
            n = (int'(vif.len) > 8) ? 8 : int'(vif.len);
            if (n > 0) begin
               e = '{kind: 0, k: '0, l: '0, last: 0};
               evq.push_back(e);
               for (int i = 0; i < n; i++) begin
                  e = '{kind: 1, k: mk[i], l: ml[i], last: (i == n - 1)};
                  evq.push_back(e);
               end
            end
            e = '{kind: 2, k: '0, l: '0, last: 0};
            evq.push_back(e);
         end
      end else if (!(evq[0].kind == 1 && vif.stall)) begin
         void'(evq.pop_front());
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         logic       eb, ec, ev, el, ed;
         logic [9:0] ek, elv;
         eb = 0; ec = 0; ev = 0; el = 0; ed = 0; ek = '0; elv = '0;
         if (evq.size() != 0) begin
            eb = 1;
            ec = (evq[0].kind == 0);
            ev = (evq[0].kind == 1);
            ed = (evq[0].kind == 2);
            if (ev) begin
               ek  = evq[0].k;
               elv = evq[0].l;
               el  = evq[0].last;
            end
         end
         check("model_busy",  32'(vif.busy),  32'(eb));
         check("model_clear", 32'(vif.clear), 32'(ec));
         check("model_valid", 32'(vif.valid), 32'(ev));
         check("model_last",  32'(vif.last),  32'(el));
         check("model_done",  32'(vif.done),  32'(ed));
         check("model_k",     32'(vif.k),     32'(ek));
         check("model_l",     32'(vif.l),     32'(elv));
      end
   end

   // Directed stimulus with literal expectations.
   typedef struct {
      logic [9:0] k;
      logic [9:0] l;
      logic       last;
   } pair_t;

   pair_t got[$];
   int    clear_cyc, done_cyc, valid_cyc;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write(input logic sel, input logic [2:0] addr, input logic [9:0] data);
      vif.wr_en   = 1'b1;
      vif.wr_sel  = sel;
      vif.wr_addr = addr;
      vif.wr_data = data;
      step();
      vif.wr_en   = 1'b0;
   endtask

   // Cycle c counts cycles after the edge that samples start.
   task automatic run(input int ln, input logic [31:0] smask, input bit busy_cmds,
                      input bit wr_with_start, input logic ws, input logic [2:0] wa,
                      input logic [9:0] wd);
      pair_t p;
      got.delete();
      clear_cyc = -1;
      done_cyc  = -1;
      valid_cyc = 0;
      vif.len   = 4'(ln);
      vif.start = 1'b1;
      if (wr_with_start) begin
         vif.wr_en   = 1'b1;
         vif.wr_sel  = ws;
         vif.wr_addr = wa;
         vif.wr_data = wd;
      end
      step();
      vif.start = 1'b0;
      vif.wr_en = 1'b0;
      for (int c = 1; c < 40; c++) begin
         vif.stall = smask[c];
         if (vif.clear && clear_cyc < 0) clear_cyc = c;
         if (vif.valid) valid_cyc++;
         if (vif.valid && !smask[c]) begin
            p.k = vif.k; p.l = vif.l; p.last = vif.last;
            got.push_back(p);
         end
         if (vif.done) begin
            done_cyc = c;
            break;
         end
         if (busy_cmds && c == 3) begin
            vif.wr_en   = 1'b1;
            vif.wr_sel  = 1'b0;
            vif.wr_addr = 3'd1;
            vif.wr_data = 10'd99;
            vif.start   = 1'b1;
            vif.len     = 4'd5;
         end else begin
            vif.wr_en = 1'b0;
            vif.start = 1'b0;
         end
         step();
      end
      vif.stall = 1'b0;
      vif.wr_en = 1'b0;
      vif.start = 1'b0;
      if (done_cyc < 0) check("run_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_pairs(input string tag, input int n, input int k0, input int l0);
      check({tag, "_count"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < n && i < got.size(); i++) begin
         check({tag, "_k"},    32'(got[i].k),    32'(k0 + i));
         check({tag, "_l"},    32'(got[i].l),    32'(l0 + i));
         check({tag, "_last"}, 32'(got[i].last), 32'(i == n - 1));
      end
   endtask

   initial begin
      int mac;
      reset       = 1'b1;
      vif.wr_en   = 1'b0;
      vif.wr_sel  = 1'b0;
      vif.wr_addr = '0;
      vif.wr_data = '0;
      vif.len     = '0;
      vif.start   = 1'b0;
      vif.stall   = 1'b0;
      step();
      chk_en = 1;
      step();
      check("rst_busy",  32'(vif.busy),  32'd0);
      check("rst_valid", 32'(vif.valid), 32'd0);
      check("rst_k",     32'(vif.k),     32'd0);
      check("rst_clear", 32'(vif.clear), 32'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 3; i++) begin
         write(1'b0, 3'(i), 10'(3 + i));
         write(1'b1, 3'(i), 10'(6 + i));
      end

      // nominal
      run(3, 32'd0, 0, 0, 0, 0, 0);
      check("nom_clear_cyc", 32'(clear_cyc), 32'd1);
      check("nom_done_cyc",  32'(done_cyc),  32'd5);
      check("nom_valid_cyc", 32'(valid_cyc), 32'd3);
      expect_pairs("nom", 3, 3, 6);
      mac = 0;
      foreach (got[i]) mac += int'(got[i].k) * int'(got[i].l);
      check("nom_mac", 32'(mac), 32'd86);
      step();
      check("nom_busy_after", 32'(vif.busy), 32'd0);

      // stall on the cycle showing (4,7) and the next one
      run(3, 32'h18, 0, 0, 0, 0, 0);
      check("stall_done_cyc",  32'(done_cyc),  32'd7);
      check("stall_valid_cyc", 32'(valid_cyc), 32'd5);
      expect_pairs("stall", 3, 3, 6);
      step();

      // len = 0
      run(0, 32'd0, 0, 0, 0, 0, 0);
      check("len0_done_cyc",  32'(done_cyc),  32'd1);
      check("len0_clear_cyc", 32'(clear_cyc), 32'hFFFF_FFFF);
      check("len0_valid_cyc", 32'(valid_cyc), 32'd0);
      check("len0_busy",      32'(vif.busy),  32'd1);
      step();
      check("len0_busy_after", 32'(vif.busy), 32'd0);

      // write and start while busy are ignored
      run(3, 32'd0, 1, 0, 0, 0, 0);
      check("busycmd_done_cyc", 32'(done_cyc), 32'd5);
      expect_pairs("busycmd", 3, 3, 6);
      for (int i = 0; i < 3; i++) begin
         step();
         check("busycmd_no_rerun", 32'(vif.busy), 32'd0);
      end
      run(3, 32'd0, 0, 0, 0, 0, 0);
      expect_pairs("busycmd_next", 3, 3, 6);
      step();

      // reset while (4,7) is shown
      vif.len   = 4'd3;
      vif.start = 1'b1;
      step();
      vif.start = 1'b0;
      step();
      step();
      check("rstmid_k_before", 32'(vif.k), 32'd4);
      check("rstmid_l_before", 32'(vif.l), 32'd7);
      reset = 1'b1;
      step();
      check("rstmid_valid", 32'(vif.valid), 32'd0);
      check("rstmid_k",     32'(vif.k),     32'd0);
      check("rstmid_l",     32'(vif.l),     32'd0);
      check("rstmid_busy",  32'(vif.busy),  32'd0);
      reset = 1'b0;
      step();
      run(3, 32'd0, 0, 0, 0, 0, 0);
      expect_pairs("rstmid_replay", 3, 3, 6);
      step();

      // len = 12 clamps to 8; L[7] written in the same cycle as start
      for (int i = 0; i < 8; i++) write(1'b0, 3'(i), 10'(10 + i));
      for (int i = 0; i < 7; i++) write(1'b1, 3'(i), 10'(20 + i));
      run(12, 32'd0, 0, 1, 1'b1, 3'd7, 10'd27);
      check("len12_clear_cyc", 32'(clear_cyc), 32'd1);
      check("len12_done_cyc",  32'(done_cyc),  32'd10);
      expect_pairs("len12", 8, 10, 20);
      step();
      step();

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vector_pair_streamer.md
Name: vector_pair_streamer

Overview:
- Transmit-side companion to the multiply-accumulate vector unit.
- Holds two operand vectors (bank K, bank L) in internal register storage, written one element at a time.
- On a start command it emits a one-cycle accumulator-clear pulse, then streams element pairs (k[i], l[i]) in index order with valid/last flags, honouring a downstream stall. It finishes with a done pulse.
- Sits between the host/testbench write port and the k/l inputs of the accumulating multiplier.

Parameters:
- WIDTH, 10, element width in bits (matches the multiplier's k/l width).
- DEPTH, 8, maximum vector length (elements per bank).
- AW, 3, address width; DEPTH = 2**AW.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  element write strobe.
- wr_sel  input  1  write bank select: 0 = K bank, 1 = L bank.
- wr_addr  input  AW  element index to write.
- wr_data  input  WIDTH  element value.
- len  input  AW+1  vector length; sampled on an accepted start.
- start  input  1  begin a streaming run.
- stall  input  1  downstream hold request.
- busy  output  1  a run is in progress.
- k  output  WIDTH  K-bank element of the current pair.
- l  output  WIDTH  L-bank element of the current pair.
- valid  output  1  k/l carry a pair.
- last  output  1  the current pair is the final one.
- clear  output  1  one-cycle accumulator clear.
- done  output  1  one-cycle run-complete pulse.

Behaviour:
- All outputs are registered.
- Reset: state IDLE; busy, valid, last, clear, done = 0; k, l = 0; index and stored length = 0.
- Reset does not clear bank contents.
- Reset asserted mid-run returns the block to IDLE on the next edge, with all outputs at their reset values.
- Writes:
  - Accepted only in IDLE with wr_en=1; the write lands in bank[wr_sel][wr_addr] at the clock edge.
  - wr_en while busy is ignored and banks are unchanged.
- State machine (IDLE, CLEAR, STREAM, DONE):
  - IDLE: if start=1, capture eff_len = min(len, DEPTH) and set idx=0.
    - eff_len=0: go to DONE (no clear, no pairs).
    - Otherwise: go to CLEAR.
    - start and wr_en in the same IDLE cycle: the write is performed and the run starts; the written value is visible to the run.
  - CLEAR: clear=1 and busy=1 for exactly one cycle, then STREAM.
  - STREAM: registered output shows pair idx, with valid=1 and last=(idx==eff_len-1).
    - A pair is consumed on any cycle where valid=1 and stall=0.
    - When stall=1, k, l, valid, last and idx hold.
    - After the last pair is consumed, go to DONE.
  - DONE: done=1 for one cycle, valid=0, k=l=0, then IDLE.
- busy=1 in CLEAR, STREAM and DONE; busy=0 in IDLE.
- start while busy is ignored; len is not re-sampled.
- Timing without stalls, start sampled at edge T:
  - clear at cycle T+1.
  - Pair i valid at cycle T+2+i.
  - done at cycle T+2+eff_len.
  - busy falls at T+3+eff_len.
- stall has no effect outside STREAM; CLEAR and DONE always last one cycle.
- len > DEPTH is clamped to DEPTH; values wider than AW+1 bits cannot occur.
- k and l are 0 whenever valid=0.

Test Plan:
- Nominal run: write K=[3,4,5] and L=[6,7,8] at addr 0..2, len=3, start pulse.
  - Required: clear at T+1; pairs (3,6), (4,7), (5,8) at T+2..T+4 with last only on (5,8); done at T+5.
  - A downstream multiply-accumulate result of 86.
- Stall: same vectors, stall=1 during the cycle showing (4,7) and the next cycle.
  - Required: (4,7) held 3 cycles, no pair skipped or duplicated; done delayed by 2 cycles.
- Length limits:
  - len=0: no clear, no valid; done at T+1; busy high for one cycle.
  - len=12 with DEPTH=8: exactly 8 pairs, last on index 7.
- Busy-time commands: during STREAM, wr_en to K[1]=99 and a second start pulse.
  - Required: the ongoing run is unaffected; the next run shows K[1] still 4; no extra run is triggered.
- Reset mid-run: reset asserted while (4,7) is valid.
  - Required: next cycle outputs are 0 and busy=0.
  - A new start replays (3,6), (4,7), (5,8), since bank contents are retained.
